scale_coord_gen: RTL and testbench

//  Consumer of the scaler coefficient unit: turns per-frame kX/kY step factors (u2.6 input pixels per

---
 rtl/scale_coord_gen.sv | 247 ++++++++++++++++++++++++
 tb/tb_scale_coord_gen.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/scale_coord_gen.sv
// scale_coord_gen
//   Turns per-frame kX/kY step factors (u2.6 source pixels per output pixel)
//   into one beat per output pixel carrying the top-left source coordinate,
//   its clamped right/lower neighbour and the bilinear fractions. A frame
//   starts on a rising edge of iVsyn while inEn is high; the frame parameters
//   are captured at that moment. Beats are handed over with valid/ready.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   inEn                      enable from coefficient unit (low aborts a frame)
//   iVsyn                     frame sync, rising edge starts a frame
//   kX, kY                    step per output pixel / line
//   xBgn, xEnd, yBgn, yEnd    inclusive crop window
//   outXRes, outYRes          output width / height minus 1
//   oValid, iReady            beat handshake
//   srcX, srcY, srcXN, srcYN  source pixel and clamped neighbour
//   fracX, fracY              interpolation weights
//   lineStart, lineEnd, frameEnd  beat qualifiers
//   frmErr                    one-cycle pulse on iVsyn edge while running
//
// state | meaning
// IDLE  | no frame in progress, oValid low, waiting for vsync edge
// RUN   | frame in progress, presenting/handing over beats

module scale_coord_gen #(
  parameter int INPUT_RES_WIDTH  = 11,
  parameter int OUTPUT_RES_WIDTH = 11,
  parameter int SCALE_BITS       = 8,
  parameter int FRAC_BITS        = 6
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        inEn,
  input  logic                        iVsyn,
  input  logic [SCALE_BITS-1:0]       kX,
  input  logic [SCALE_BITS-1:0]       kY,
  input  logic [INPUT_RES_WIDTH-1:0]  xBgn,
  input  logic [INPUT_RES_WIDTH-1:0]  xEnd,
  input  logic [INPUT_RES_WIDTH-1:0]  yBgn,
  input  logic [INPUT_RES_WIDTH-1:0]  yEnd,
  input  logic [OUTPUT_RES_WIDTH-1:0] outXRes,
  input  logic [OUTPUT_RES_WIDTH-1:0] outYRes,
  output logic                        oValid,
  input  logic                        iReady,
  output logic [INPUT_RES_WIDTH-1:0]  srcX,
  output logic [INPUT_RES_WIDTH-1:0]  srcY,
  output logic [INPUT_RES_WIDTH-1:0]  srcXN,
  output logic [INPUT_RES_WIDTH-1:0]  srcYN,
  output logic [FRAC_BITS-1:0]        fracX,
  output logic [FRAC_BITS-1:0]        fracY,
  output logic                        lineStart,
  output logic                        lineEnd,
  output logic                        frameEnd,
  output logic                        frmErr
);

  localparam int IW  = INPUT_RES_WIDTH;
  localparam int OW  = OUTPUT_RES_WIDTH;
  localparam int ACC = OUTPUT_RES_WIDTH + SCALE_BITS;
  localparam int IPW = ACC - FRAC_BITS;
  // wide enough that crop begin plus integer step never wraps before the clamp
  localparam int WW  = ((IW > IPW) ? IW : IPW) + 1;
  localparam int MW  = 2 * IW + FRAC_BITS;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t state_q, state_d;

  logic                  vs_d;
  logic                  vs_rise;
  logic                  accept;
  logic                  start, adv, to_idle, frm_err_d;

  logic [SCALE_BITS-1:0] kx_l, ky_l;
  logic [IW-1:0]         xb_l, xe_l, yb_l, ye_l;
  logic [OW-1:0]         xr_l, yr_l;

  logic [OW-1:0]         ox_q, oy_q, n_ox, n_oy;
  logic [ACC-1:0]        ax_q, ay_q, n_ax, n_ay;

  logic [IW-1:0]         c_xb, c_xe, c_yb, c_ye;
  logic [OW-1:0]         c_xr, c_yr;
  logic [MW-1:0]         xm, ym;

  // returns {src, src_neighbour, frac}; clamped beats get zero fraction
  function automatic logic [MW-1:0] map_coord(input logic [IW-1:0]  bgn,
                                               input logic [IW-1:0]  lim,
                                               input logic [ACC-1:0] acc);
    logic [WW-1:0]        wide;
    logic [IW-1:0]        src;
    logic [IW-1:0]        srcn;
    logic [FRAC_BITS-1:0] frac;
    wide = WW'(bgn) + WW'(acc[ACC-1:FRAC_BITS]);
    if (wide > WW'(lim)) begin
      src  = lim;
      frac = '0;
    end else begin
      src  = wide[IW-1:0];
      frac = acc[FRAC_BITS-1:0];
    end
    srcn = (src < lim) ? src + IW'(1) : lim;
    return {src, srcn, frac};
  endfunction

  assign vs_rise = iVsyn & ~vs_d;
  assign accept  = oValid & iReady;

  always_comb begin
    state_d   = state_q;
    start     = 1'b0;
    adv       = 1'b0;
    to_idle   = 1'b0;
    frm_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (vs_rise && inEn) begin
          start   = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (vs_rise && !(accept && frameEnd)) frm_err_d = 1'b1;
        if (!inEn) begin
          to_idle = 1'b1;
          state_d = IDLE;
        end else if (accept) begin
          if (frameEnd) begin
            if (vs_rise) begin
              start = 1'b1;
            end else begin
              to_idle = 1'b1;
              state_d = IDLE;
            end
          end else begin
            adv = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A starting frame uses the live inputs; a running frame uses the captured copy.
  always_comb begin
    c_xb = start ? xBgn    : xb_l;
    c_xe = start ? xEnd    : xe_l;
    c_yb = start ? yBgn    : yb_l;
    c_ye = start ? yEnd    : ye_l;
    c_xr = start ? outXRes : xr_l;
    c_yr = start ? outYRes : yr_l;

    n_ox = '0;
    n_oy = '0;
    n_ax = '0;
    n_ay = '0;
    if (!start) begin
      if (ox_q == xr_l) begin
        n_oy = oy_q + OW'(1);
        n_ay = ay_q + ACC'(ky_l);
      end else begin
        n_ox = ox_q + OW'(1);
        n_ax = ax_q + ACC'(kx_l);
        n_oy = oy_q;
        n_ay = ay_q;
      end
    end

    xm = map_coord(c_xb, c_xe, n_ax);
    ym = map_coord(c_yb, c_ye, n_ay);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      vs_d      <= 1'b0;
      frmErr    <= 1'b0;
      kx_l      <= '0;
      ky_l      <= '0;
      xb_l      <= '0;
      xe_l      <= '0;
      yb_l      <= '0;
      ye_l      <= '0;
      xr_l      <= '0;
      yr_l      <= '0;
      ox_q      <= '0;
      oy_q      <= '0;
      ax_q      <= '0;
      ay_q      <= '0;
      oValid    <= 1'b0;
      srcX      <= '0;
      srcY      <= '0;
      srcXN     <= '0;
      srcYN     <= '0;
      fracX     <= '0;
      fracY     <= '0;
      lineStart <= 1'b0;
      lineEnd   <= 1'b0;
      frameEnd  <= 1'b0;
    end else begin
      state_q <= state_d;
      vs_d    <= iVsyn;
      frmErr  <= frm_err_d;
      if (start) begin
        kx_l <= kX;
        ky_l <= kY;
        xb_l <= xBgn;
        xe_l <= xEnd;
        yb_l <= yBgn;
        ye_l <= yEnd;
        xr_l <= outXRes;
        yr_l <= outYRes;
      end
      if (start || adv) begin
        ox_q      <= n_ox;
        oy_q      <= n_oy;
        ax_q      <= n_ax;
        ay_q      <= n_ay;
        oValid    <= 1'b1;
        srcX      <= xm[MW-1 -: IW];
        srcXN     <= xm[FRAC_BITS +: IW];
        fracX     <= xm[FRAC_BITS-1:0];
        srcY      <= ym[MW-1 -: IW];
        srcYN     <= ym[FRAC_BITS +: IW];
        fracY     <= ym[FRAC_BITS-1:0];
        lineStart <= (n_ox == '0);
        lineEnd   <= (n_ox == c_xr);
        frameEnd  <= (n_ox == c_xr) && (n_oy == c_yr);
      end else if (to_idle) begin
        ox_q      <= '0;
        oy_q      <= '0;
        ax_q      <= '0;
        ay_q      <= '0;
        oValid    <= 1'b0;
        srcX      <= '0;
        srcY      <= '0;
        srcXN     <= '0;
        srcYN     <= '0;
        fracX     <= '0;
        fracY     <= '0;
        lineStart <= 1'b0;
        lineEnd   <= 1'b0;
        frameEnd  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_scale_coord_gen.sv
module tb_scale_coord_gen;

  logic        clk = 1'b0;
  logic        rst, inEn, iVsyn, iReady;
  logic [7:0]  kX, kY;
  logic [10:0] xBgn, xEnd, yBgn, yEnd, outXRes, outYRes;
  logic        oValid;
  logic [10:0] srcX, srcY, srcXN, srcYN;
  logic [5:0]  fracX, fracY;
  logic        lineStart, lineEnd, frameEnd, frmErr;

  logic [63:0] exp_q[$];
  logic [63:0] dut_beat;
  int n_chk  = 0;
  int n_pass = 0;
  int beat_cnt = 0;

  always #5 clk = ~clk;

  scale_coord_gen dut (
    .clk(clk), .rst(rst), .inEn(inEn), .iVsyn(iVsyn),
    .kX(kX), .kY(kY), .xBgn(xBgn), .xEnd(xEnd), .yBgn(yBgn), .yEnd(yEnd),
    .outXRes(outXRes), .outYRes(outYRes),
    .oValid(oValid), .iReady(iReady),
    .srcX(srcX), .srcY(srcY), .srcXN(srcXN), .srcYN(srcYN),
    .fracX(fracX), .fracY(fracY),
    .lineStart(lineStart), .lineEnd(lineEnd), .frameEnd(frameEnd),
    .frmErr(frmErr)
  );

  assign dut_beat = {5'b0, srcX, srcY, srcXN, srcYN, fracX, fracY,
                     lineStart, lineEnd, frameEnd};

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // reference mapping of one axis: source, neighbour, fraction
  task automatic ref_coord(input int bgn, input int lim, input int acc,
                           output int src, output int srcn, output int frac);
    int wide;
    wide = bgn + (acc >> 6);
    if (wide > lim) begin
      src  = lim;
      frac = 0;
    end else begin
      src  = wide;
      frac = acc % 64;
    end
    srcn = (src + 1 > lim) ? lim : src + 1;
  endtask

  // expected beats of one frame from the inputs currently driven
  task automatic push_frame();
    int sx, sxn, fx, sy, syn, fy;
    bit ls, le, fe;
    for (int oy = 0; oy <= int'(outYRes); oy++) begin
      for (int ox = 0; ox <= int'(outXRes); ox++) begin
        ref_coord(int'(xBgn), int'(xEnd), ox * int'(kX), sx, sxn, fx);
        ref_coord(int'(yBgn), int'(yEnd), oy * int'(kY), sy, syn, fy);
        ls = (ox == 0);
        le = (ox == int'(outXRes));
        fe = le && (oy == int'(outYRes));
        exp_q.push_back({5'b0, 11'(sx), 11'(sy), 11'(sxn), 11'(syn),
                         6'(fx), 6'(fy), ls, le, fe});
      end
    end
  endtask

  task automatic set_cfg(input int kx, input int ky, input int xb, input int xe,
                         input int yb, input int ye, input int xr, input int yr);
    kX = 8'(kx); kY = 8'(ky);
    xBgn = 11'(xb); xEnd = 11'(xe); yBgn = 11'(yb); yEnd = 11'(ye);
    outXRes = 11'(xr); outYRes = 11'(yr);
  endtask

  task automatic start_frame();
    push_frame();
    iVsyn = 1'b1;
    tick();
    check("start_latency", {63'b0, oValid}, 64'd1);
    iVsyn = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max_cyc, input bit rnd);
    int cnt = 0;
    while (exp_q.size() != 0 && cnt < max_cyc) begin
      if (rnd) iReady = 1'($urandom_range(0, 1));
      tick();
      cnt++;
    end
    iReady = 1'b1;
    check({tag, "_drain"}, 64'(exp_q.size()), 64'd0);
    check({tag, "_idle"}, {63'b0, oValid}, 64'd0);
    exp_q.delete();
  endtask

  // scoreboard: every presented beat must match the head; pop on handshake
  always @(negedge clk) begin
    if (!rst && oValid) begin
      if (exp_q.size() == 0) begin
        check("spurious_beat", {63'b0, oValid}, 64'd0);
      end else begin
        check("beat", dut_beat, exp_q[0]);
        if (iReady) begin
          void'(exp_q.pop_front());
          beat_cnt++;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt;
    rst = 1'b1; inEn = 1'b1; iVsyn = 1'b0; iReady = 1'b1;
    set_cfg(0, 0, 0, 0, 0, 0, 0, 0);
    tick(); tick();
    check("reset_beat", dut_beat, 64'd0);
    check("reset_flags", {62'b0, oValid, frmErr}, 64'd0);
    rst = 1'b0;
    tick();

    // half-pixel steps, 8x8 output over a 4x4 crop
    set_cfg(32, 32, 0, 3, 0, 3, 7, 7);
    beat_cnt = 0;
    start_frame();
    wait_done("t1", 300, 1'b0);
    check("t1_beats", 64'(beat_cnt), 64'd64);
    tick();

    // non-zero crop origin with fractional steps
    set_cfg(80, 64, 10, 13, 5, 9, 3, 2);
    start_frame();
    wait_done("t2", 100, 1'b0);
    tick();

    // steps that overrun the crop, random back-pressure
    set_cfg(128, 128, 0, 3, 0, 3, 7, 1);
    start_frame();
    wait_done("t3", 300, 1'b1);
    tick();

    // stall of 5 cycles after 3 accepted beats
    set_cfg(32, 32, 0, 3, 0, 3, 7, 7);
    start_frame();
    repeat (3) tick();
    iReady = 1'b0;
    repeat (5) tick();
    iReady = 1'b1;
    wait_done("t4", 300, 1'b0);
    tick();

    // vsync edge mid-frame, inputs changed mid-frame
    set_cfg(80, 48, 4, 12, 2, 20, 5, 4);
    start_frame();
    repeat (5) tick();
    set_cfg(255, 255, 100, 200, 100, 200, 9, 9);
    iVsyn = 1'b1;
    tick();
    check("t5_frmerr_pulse", {63'b0, frmErr}, 64'd1);
    iVsyn = 1'b0;
    tick();
    check("t5_frmerr_clear", {63'b0, frmErr}, 64'd0);
    wait_done("t5", 300, 1'b0);
    tick();

    // back-to-back frames: vsync edge in the frameEnd accept cycle
    set_cfg(32, 32, 0, 3, 0, 3, 3, 1);
    start_frame();
    cnt = 0;
    while (exp_q.size() != 1 && cnt < 100) begin
      tick();
      cnt++;
    end
    check("t6_reach_last", 64'(exp_q.size()), 64'd1);
    set_cfg(64, 96, 1, 6, 2, 7, 2, 2);
    push_frame();
    iVsyn = 1'b1;
    tick();
    check("t6_b2b_valid", {63'b0, oValid}, 64'd1);
    check("t6_b2b_noerr", {63'b0, frmErr}, 64'd0);
    iVsyn = 1'b0;
    wait_done("t6", 100, 1'b0);
    tick();

    // reset at beat 10
    set_cfg(32, 32, 0, 3, 0, 3, 7, 7);
    start_frame();
    repeat (9) tick();
    rst = 1'b1;
    tick();
    check("t7_rst_valid", {63'b0, oValid}, 64'd0);
    check("t7_rst_beat", dut_beat, 64'd0);
    exp_q.delete();
    rst = 1'b0;
    repeat (3) tick();
    check("t7_no_restart", {63'b0, oValid}, 64'd0);

    // vsync edge with inEn low starts nothing
    inEn = 1'b0;
    iVsyn = 1'b1;
    tick();
    iVsyn = 1'b0;
    repeat (3) tick();
    check("t8_disabled", {63'b0, oValid}, 64'd0);
    inEn = 1'b1;
    tick();

    // inEn drop mid-frame aborts even while stalled
    set_cfg(32, 32, 0, 3, 0, 3, 7, 7);
    start_frame();
    repeat (6) tick();
    iReady = 1'b0;
    inEn = 1'b0;
    tick();
    check("t9_abort", {63'b0, oValid}, 64'd0);
    exp_q.delete();
    iReady = 1'b1;
    tick();
    check("t9_stay_idle", {63'b0, oValid}, 64'd0);
    inEn = 1'b1;
    tick();

    // single beat frame, then single column
    set_cfg(64, 64, 2, 9, 3, 9, 0, 0);
    start_frame();
    wait_done("t10", 20, 1'b0);
    tick();
    set_cfg(64, 100, 2, 9, 3, 5, 0, 3);
    start_frame();
    wait_done("t11", 20, 1'b0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
